// File: rtl/adc_spi_responder_if.sv
// Pin-level bundle between an SPI master (or its bench) and the ADC responder.
// Inputs come straight from pins that are asynchronous to clk; the responder synchronises them.
interface adc_spi_responder_if #(
   parameter int DATA_W = 8
);
   logic              cs_n;
   logic              sclk;
   logic [DATA_W-1:0] adc_data;
   logic              sdata;
   logic              sdata_oe;
   logic              busy;
   logic              frame_done;
   logic              frame_abort;
   logic [DATA_W-1:0] sample_out;
   logic [1:0]        state_dbg;

   // Protocol: cs_n falling opens a frame and sclk falling advances it by one bit.
   // The master samples sdata on sclk rising, and cs_n rising closes the frame.
   modport slave (
      input  cs_n,
      input  sclk,
      input  adc_data,
      output sdata,
      output sdata_oe,
      output busy,
      output frame_done,
      output frame_abort,
      output sample_out,
      output state_dbg
   );

   modport master (
      output cs_n,
      output sclk,
      output adc_data,
      input  sdata,
      input  sdata_oe,
      input  busy,
      input  frame_done,
      input  frame_abort,
      input  sample_out,
      input  state_dbg
   );
endinterface

// File: rtl/adc_spi_responder.sv
// Emulates a serial ADC: each frame is LEAD_ZEROS zeros, then the latched sample MSB first,
// then TRAIL_ZEROS zeros. The frame advances on synchronised sclk falls.
module adc_spi_responder #(
   parameter int LEAD_ZEROS  = 3,
   parameter int DATA_W      = 8,
   parameter int TRAIL_ZEROS = 4
) (
   input  logic                  clk,
   input  logic                  n_rst,
   adc_spi_responder_if.slave    bus
);
   localparam int FRAME = LEAD_ZEROS + DATA_W + TRAIL_ZEROS;
   localparam int IDX_W = $clog2(FRAME + 1);

   localparam logic [IDX_W-1:0] DATA_START = IDX_W'(LEAD_ZEROS);
   localparam logic [IDX_W-1:0] DATA_END   = IDX_W'(LEAD_ZEROS + DATA_W);
   localparam logic [IDX_W-1:0] FRAME_LEN  = IDX_W'(FRAME);
   localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   logic cs_sync1_q, cs_sync2_q, cs_hist_q;
   logic sclk_sync1_q, sclk_sync2_q, sclk_hist_q;
   logic cs_fall, cs_rise, sclk_fall;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] sample_q, sample_d;
   logic              sdata_q, sdata_d;
   logic              oe_q, oe_d;
   logic              done_q, done_d;
   logic              abort_q, abort_d;
   logic [IDX_W-1:0]  next_idx;

   // Synchronisers preset high so that leaving reset with idle-high pins looks like no edge.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cs_sync1_q   <= 1'b1;
         cs_sync2_q   <= 1'b1;
         cs_hist_q    <= 1'b1;
         sclk_sync1_q <= 1'b1;
         sclk_sync2_q <= 1'b1;
         sclk_hist_q  <= 1'b1;
      end else begin
         cs_sync1_q   <= bus.cs_n;
         cs_sync2_q   <= cs_sync1_q;
         cs_hist_q    <= cs_sync2_q;
         sclk_sync1_q <= bus.sclk;
         sclk_sync2_q <= sclk_sync1_q;
         sclk_hist_q  <= sclk_sync2_q;
      end
   end

   assign cs_fall   =  cs_hist_q   & ~cs_sync2_q;
   assign cs_rise   = ~cs_hist_q   &  cs_sync2_q;
   assign sclk_fall =  sclk_hist_q & ~sclk_sync2_q;
   assign next_idx  = bit_idx_q + IDX_ONE;

   function automatic logic in_data(input logic [IDX_W-1:0] k);
      return (k >= DATA_START) && (k < DATA_END);
   endfunction

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q   <= ST_IDLE;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         sample_q  <= '0;
         sdata_q   <= 1'b0;
         oe_q      <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         sample_q  <= sample_d;
         sdata_q   <= sdata_d;
         oe_q      <= oe_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
      end
   end

   // The shift register's MSB is always the next sample bit to emit; it shifts only
   // when a data-region bit goes out, so lead/trail zeros leave it untouched.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      sample_d  = sample_q;
      sdata_d   = sdata_q;
      oe_d      = oe_q;
      done_d    = 1'b0;
      abort_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            sdata_d = 1'b0;
            oe_d    = 1'b0;
            if (cs_fall) begin
               sample_d  = bus.adc_data;
               bit_idx_d = '0;
               oe_d      = 1'b1;
               state_d   = ST_SHIFT;
               if (in_data('0)) begin
                  sdata_d = bus.adc_data[DATA_W-1];
                  shreg_d = bus.adc_data << 1;
               end else begin
                  sdata_d = 1'b0;
                  shreg_d = bus.adc_data;
               end
            end
         end

         ST_SHIFT: begin
            // cs_n rising takes priority; a coincident sclk fall is dropped.
            if (cs_rise) begin
               sdata_d = 1'b0;
               oe_d    = 1'b0;
               abort_d = 1'b1;
               state_d = ST_IDLE;
            end else if (sclk_fall) begin
               bit_idx_d = next_idx;
               if (next_idx < FRAME_LEN) begin
                  if (in_data(next_idx)) begin
                     sdata_d = shreg_q[DATA_W-1];
                     shreg_d = shreg_q << 1;
                  end else begin
                     sdata_d = 1'b0;
                  end
               end else begin
                  sdata_d = 1'b0;
                  state_d = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            sdata_d = 1'b0;
            if (cs_rise) begin
               oe_d    = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: begin
            sdata_d = 1'b0;
            oe_d    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.sdata       = sdata_q;
   assign bus.sdata_oe    = oe_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.frame_done  = done_q;
   assign bus.frame_abort = abort_q;
   assign bus.sample_out  = sample_q;
   assign bus.state_dbg   = state_q;
endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameter LEAD_ZEROS, default 3, is the number of leading zero bits in each frame.
REQ-002 Parameter DATA_W, default 8, is the sample width, sent MSB first.
REQ-003 Parameter TRAIL_ZEROS, default 4, is the number of trailing zero bits; FRAME = LEAD_ZEROS+DATA_W+TRAIL_ZEROS (default 15).
REQ-004 clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-005 n_rst  input  1  reset, synchronous, active-low.
REQ-006 cs_n  input  1  chip select from the SPI master, asynchronous to clk, idles high.
REQ-007 sclk  input  1  serial clock from the master, asynchronous to clk, idles high, much slower than clk (≥8 clk periods per sclk phase).
REQ-008 adc_data  input  DATA_W  parallel sample to emulate.
REQ-009 sdata  output  1  serial data to the master.
REQ-010 sdata_oe  output  1  1 = sdata driven, 0 = pin released (tri-state at top level).
REQ-011 busy  output  1  high while a frame is in progress (state ≠ IDLE).
REQ-012 frame_done  output  1  one-clk pulse: cs_n rose after a complete frame.
REQ-013 frame_abort  output  1  one-clk pulse: cs_n rose before the frame completed.
REQ-014 sample_out  output  DATA_W  copy of the sample latched for the current or last frame.

Function
REQ-015 cs_n and sclk SHALL each pass through a 2-flop synchronizer plus one history flop; edges are detected as sync2 ≠ history.
REQ-016 Latency: a pin transition first captured at rising edge N SHALL take effect on registered outputs at edge N+2.
REQ-017 FSM states SHALL be IDLE, SHIFT, HOLD.
REQ-018 IDLE, cs_n fall: latch adc_data into shift register and sample_out, bit index := 0, sdata := frame bit 0, sdata_oe := 1, go SHIFT.
REQ-019 Frame bit k SHALL be 0 for k < LEAD_ZEROS, adc_data[DATA_W-1-(k-LEAD_ZEROS)] for k < LEAD_ZEROS+DATA_W, else 0.
REQ-020 SHIFT, sclk fall: bit index increments; if the new index < FRAME, sdata := frame bit (index), else sdata := 0 and go HOLD.
REQ-021 sclk rising edges SHALL have no effect, since the master samples on the rising edge.
REQ-022 SHIFT, cs_n rise: go IDLE, sdata := 0, sdata_oe := 0, pulse frame_abort.
REQ-023 HOLD: sdata stays 0 with oe = 1; further sclk falls are ignored; on cs_n rise go IDLE, oe := 0, pulse frame_done.
REQ-024 A cs_n rise and an sclk fall detected in the same cycle: the cs_n rise SHALL win, and the sclk edge is discarded.
REQ-025 In IDLE, sclk edges SHALL be ignored, and sdata = 0, oe = 0.
REQ-026 adc_data changes after the latch SHALL NOT affect the frame in flight.
REQ-027 A cs_n fall in the same cycle the FSM returns to IDLE cannot occur, because cs_n is still high; cs_n must be high ≥1 synchronized cycle before a new frame.

Reset
REQ-028 When n_rst = 0 at a rising edge: state := IDLE, sdata := 0, sdata_oe := 0, busy := 0, frame_done := 0, frame_abort := 0, sample_out := 0, bit index := 0, shift register := 0.
REQ-029 During reset the cs_n and sclk synchronizer and history flops SHALL be set to 1, so release causes no false edge.
REQ-030 Reset asserted mid-frame SHALL abort silently, with no frame_abort pulse; after release the block waits for a fresh cs_n fall.

Verification
REQ-031 Test 1: adc_data = 0x93, cs_n low, 15 sclk falls, cs_n high → bits 000_1001_0011_0000, sample_out = 0x93, one frame_done pulse, no abort.
REQ-032 Test 2: adc_data = 0x3A, second frame back-to-back → bits 000_0011_1010_0000, frame_done once, busy low between frames.
REQ-033 Test 3: cs_n high after 5 sclk falls → frame_abort pulses once, no frame_done, oe = 0 two clks after the captured edge.
REQ-034 Test 4: n_rst low after 7 sclk falls, release, then a full frame with 0x55 → no pulse from the first frame; second frame gives bits 000_0101_0101_0000.
REQ-035 Test 5: 20 sclk toggles with cs_n high, then adc_data changed from 0xA5 to 0xFF during a frame → no activity while idle; the frame carries 0xA5.
REQ-036 Test 6: 16th and 17th sclk falls in HOLD, with cs_n rising in the same clk as an sclk fall → sdata stays 0, frame_done (not abort) pulses.
